// File: rtl/shift_in_rx.sv
// shift_in_rx: oversampled asynchronous serial receiver (8N1) with a
// single-byte holding register, a framing-error flag and an overrun flag.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | line idle, waiting for a tick that sees rx_s low
// S_START | counting to mid start bit to confirm it is not a glitch
// S_DATA  | sampling 8 data bits, LSB first, one per OVS ticks
// S_STOP  | sampling the stop bit and loading the holding register
// S_WAIT_HI | stop bit was low (break); wait for the line to return high
module shift_in_rx #(
    parameter int OVS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_en,
    input  logic       in,
    input  logic       rd,
    output logic [7:0] data,
    output logic       rda,
    output logic       ferr,
    output logic       ovr,
    output logic       busy
);

    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            sync1_q, sync1_d;
    logic            rx_s_q, rx_s_d;
    logic [7:0]      data_q, data_d;
    logic            rda_q, rda_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            load;

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_comb begin
        sync1_d = in;
        rx_s_d  = sync1_q;
    end

    // Receive sequencer: everything advances only on baud_en ticks.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        load    = 1'b0;
        if (baud_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        tick_d  = '0;
                    end
                end
                S_START: begin
                    if (tick_q == TICK_HALF) begin
                        tick_d = '0;
                        bit_d  = '0;
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                S_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                S_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        load    = 1'b1;
                        tick_d  = '0;
                        state_d = rx_s_q ? S_IDLE : S_WAIT_HI;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                S_WAIT_HI: begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    // Holding register: a load always beats a concurrent read.
    always_comb begin
        data_d = data_q;
        rda_d  = rda_q;
        ferr_d = ferr_q;
        ovr_d  = ovr_q;
        if (load) begin
            data_d = shift_q;
            rda_d  = 1'b1;
            ferr_d = ~rx_s_q;
            ovr_d  = rda_q & ~rd;
        end else if (rd && rda_q) begin
            rda_d  = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            data_q  <= '0;
            rda_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sync1_q <= sync1_d;
            rx_s_q  <= rx_s_d;
            data_q  <= data_d;
            rda_q   <= rda_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data = data_q;
    assign rda  = rda_q;
    assign ferr = ferr_q;
    assign ovr  = ovr_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_in_rx.sv
// Testbench for shift_in_rx: directed scenarios plus random frames, with a
// scoreboard that expects one holding-register load per transmitted frame.
module tb_shift_in_rx;

    localparam int OVS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_en = 1'b0;
    logic       line = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] data;
    logic       rda, ferr, ovr, busy;

    int checks = 0;
    int passes = 0;
    int div = 1;
    int bcnt = 0;
    logic       pending = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic [9:0] exp_q[$];

    shift_in_rx #(.OVS(OVS)) dut (
        .clk(clk), .rst(rst), .baud_en(baud_en), .in(line), .rd(rd),
        .data(data), .rda(rda), .ferr(ferr), .ovr(ovr), .busy(busy)
    );

    always #5 clk = ~clk;

    // baud_en: one tick every div clocks.
    initial begin
        forever begin
            @(negedge clk);
            baud_en = (bcnt == 0);
            bcnt = (bcnt + 1 >= div) ? 0 : bcnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: a frame with byte b and stop bit s produces one load with
    // data=b, ferr=!s, ovr set if an unread byte was pending and no rd
    // coincided with the load.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int rd_at, input int rst_at);
        int bp;
        int j;
        bp = OVS * div;
        if (rst_at < 0) begin
            exp_q.push_back({~stop, pending & (rd_at < 0), b});
            pending   = 1'b1;
            last_data = b;
        end
        for (int k = 0; k < 10 * bp; k++) begin
            @(negedge clk);
            j = k / bp;
            if (j == 0)      line = 1'b0;
            else if (j == 9) line = stop;
            else             line = b[j-1];
            rd = (k == rd_at);
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                @(negedge clk);
                rst  = 1'b0;
                line = 1'b1;
                return;
            end
        end
        rd = 1'b0;
    endtask

    task automatic do_read();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        pending = 1'b0;
        chk("read_rda", rda, 0);
        chk("read_ovr", ovr, 0);
        chk("read_ferr", ferr, 0);
        chk("read_data", data, last_data);
    endtask

    // Monitor: a load shows as rda rising, or as a change of the held
    // byte/flags while rda stays high.
    initial begin
        logic       rda_p = 1'b0;
        logic       ferr_p = 1'b0;
        logic       ovr_p = 1'b0;
        logic [7:0] data_p = 8'h00;
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!rst && rda && (!rda_p || data != data_p || ferr != ferr_p || ovr != ovr_p)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_load", {22'd0, ferr, ovr, data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("load_data", data, e[7:0]);
                    chk("load_ferr", ferr, e[9]);
                    chk("load_ovr", ovr, e[8]);
                end
            end
            rda_p = rda; ferr_p = ferr; ovr_p = ovr; data_p = data;
        end
    end

    initial begin
        logic [7:0] b;
        logic       s;
        repeat (3) @(negedge clk);
        chk("rst_data", data, 0);
        chk("rst_rda", rda, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Normal frame.
        send_frame(8'hA5, 1'b1, -1, -1);
        chk("a5_rda", rda, 1);
        chk("a5_busy", busy, 0);
        chk("a5_data", data, 8'hA5);
        do_read();

        // Glitch shorter than half a bit.
        @(negedge clk);
        line = 1'b0;
        repeat (4) @(negedge clk);
        line = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_busy", busy, 0);
        chk("glitch_rda", rda, 0);
        chk("glitch_data", data, 8'hA5);

        // Framing error followed by a break, then a clean frame.
        send_frame(8'h3C, 1'b0, -1, -1);
        repeat (3 * OVS) @(negedge clk);
        chk("break_busy", busy, 1);
        line = 1'b1;
        repeat (8) @(negedge clk);
        chk("break_end_busy", busy, 0);
        send_frame(8'h11, 1'b1, -1, -1);
        repeat (4) @(negedge clk);
        do_read();

        // Overrun then clear.
        send_frame(8'h01, 1'b1, -1, -1);
        repeat (4) @(negedge clk);
        send_frame(8'h02, 1'b1, -1, -1);
        chk("ovr_data", data, 8'h02);
        chk("ovr_flag", ovr, 1);
        chk("ovr_rda", rda, 1);
        do_read();

        // Read coinciding with the load edge (stop sample lands at 9.5 bits
        // plus the 2-flop sync delay with baud_en every clock).
        send_frame(8'h55, 1'b1, -1, -1);
        repeat (4) @(negedge clk);
        send_frame(8'h7E, 1'b1, 9 * OVS + OVS / 2 + 2, -1);
        chk("coll_rda", rda, 1);
        chk("coll_data", data, 8'h7E);
        chk("coll_ovr", ovr, 0);
        do_read();

        // Reset during data bit 4, then a full frame.
        send_frame(8'h96, 1'b1, -1, 5 * OVS + OVS / 2);
        pending = 1'b0;
        last_data = 8'h00;
        @(negedge clk);
        chk("mrst_data", data, 0);
        chk("mrst_rda", rda, 0);
        chk("mrst_ferr", ferr, 0);
        chk("mrst_ovr", ovr, 0);
        chk("mrst_busy", busy, 0);
        repeat (4) @(negedge clk);
        send_frame(8'hC3, 1'b1, -1, -1);
        chk("c3_data", data, 8'hC3);
        do_read();

        // Random frames, random baud divisor, random host reads.
        for (int i = 0; i < 30; i++) begin
            div = $urandom_range(1, 3);
            line = 1'b1;
            repeat ($urandom_range(3 * div + 4, 3 * div + 30)) @(negedge clk);
            b = 8'($urandom);
            if (pending && b == last_data) b = b ^ 8'h01;
            s = ($urandom_range(0, 3) != 0);
            send_frame(b, s, -1, -1);
            line = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                repeat (2 * div + 4) @(negedge clk);
                do_read();
            end
        end

        for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
